// File: rtl/cla_sched_pkg.sv
// Shared types, widths and the signed-overflow rule for the CLA add scheduler.
package cla_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int DATA_W = 32;

  // Signed overflow: both addend signs agree but the result sign differs.
  function automatic logic ovf_calc(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit hierarchical carry-lookahead adder: 4-bit groups, 16-bit super-groups,
// full lookahead on both levels and on the carry-out.
module CLA_32bit
  import cla_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  // Carries into positions 0..3 of a 4-wide lookahead unit.
  function automatic logic [3:0] la_carry(input logic [2:0] g, input logic [2:0] p, input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic la_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [DATA_W-1:0] p_bit, g_bit, c_bit;
  logic [7:0]        gg1, pp1, c_grp;
  logic [1:0]        gg2, pp2, c_sup;

  assign p_bit = a ^ b;
  assign g_bit = a & b;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lvl1
    assign gg1[gi] = la_gen(g_bit[4*gi +: 4], p_bit[4*gi +: 4]);
    assign pp1[gi] = &p_bit[4*gi +: 4];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
    assign gg2[gi] = la_gen(gg1[4*gi +: 4], pp1[4*gi +: 4]);
    assign pp2[gi] = &pp1[4*gi +: 4];
  end

  assign c_sup[0] = cin;
  assign c_sup[1] = gg2[0] | (pp2[0] & cin);
  assign cout     = gg2[1] | (pp2[1] & gg2[0]) | (pp2[1] & pp2[0] & cin);

  for (genvar gi = 0; gi < 2; gi++) begin : g_grp_carry
    assign c_grp[4*gi +: 4] = la_carry(gg1[4*gi +: 3], pp1[4*gi +: 3], c_sup[gi]);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit_carry
    assign c_bit[4*gi +: 4] = la_carry(g_bit[4*gi +: 3], p_bit[4*gi +: 3], c_grp[gi]);
  end

  assign sum = p_bit ^ c_bit;

endmodule

// File: rtl/rr_arbiter_nreq.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] cand_hit;

  // cand[k] is the requester index k positions after ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] raw;
    assign raw          = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand[gi]     = (raw >= NREQ_W) ? IDW'(raw - NREQ_W) : raw[IDW-1:0];
    assign cand_hit[gi] = req[cand[gi]];
  end

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx = cand[k];
        grant_any = 1'b1;
      end
    end
  end

  assign grant = grant_any ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/cla_add_scheduler.sv
// Shares one CLA_32bit between NREQ round-robin requesters; one op per two cycles.
// Define CLA_SCHED_SUB_EN to add the per-requester req_sub (x - y) input.
module cla_add_scheduler
  import cla_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_x,
  input  logic [DATA_W*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]        req_cin,
`ifdef CLA_SCHED_SUB_EN
  input  logic [NREQ-1:0]        req_sub,
`endif
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  output logic [IDW-1:0]         rsp_id
);

  sched_state_e      state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic              cin_q, cin_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
`ifdef CLA_SCHED_SUB_EN
  logic              sub_q, sub_d;
`endif

  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              accept_en, accept;
  logic [DATA_W-1:0] add_y, add_sum;
  logic              add_cin, add_cout;

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // New work is taken only when nothing is pending, or the pending result retires now.
  assign accept_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = rst_n && accept_en && grant_any;
  assign req_ready = accept ? grant_oh : '0;

`ifdef CLA_SCHED_SUB_EN
  assign add_y   = sub_q ? ~y_q : y_q;
  assign add_cin = sub_q | cin_q;
`else
  assign add_y   = y_q;
  assign add_cin = cin_q;
`endif

  CLA_32bit u_cla (
    .a    (x_q),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
`ifdef CLA_SCHED_SUB_EN
    sub_d       = sub_q;
`endif

    if (accept) begin
      x_d      = req_x[int'(grant_idx)*DATA_W +: DATA_W];
      y_d      = req_y[int'(grant_idx)*DATA_W +: DATA_W];
      cin_d    = req_cin[grant_idx];
      id_d     = grant_idx;
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
`ifdef CLA_SCHED_SUB_EN
      sub_d    = req_sub[grant_idx];
`endif
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_ovf_d   = ovf_calc(x_q[DATA_W-1], add_y[DATA_W-1], add_sum[DATA_W-1]);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? CALC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
`ifdef CLA_SCHED_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
`ifdef CLA_SCHED_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;

endmodule
